// File: rtl/wrr_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_arbiter
// Weighted round-robin arbiter. One datapath slot is shared among CLIENTS
// requesters; each client may hold the slot for up to its programmed weight
// in consecutive grant cycles before the round-robin search moves on.
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   request         in   [CLIENTS]   per-client request (held until granted)
//   stall           in   downstream stall; suppresses grants, freezes scheduling
//   weight_wr_en    in   weight write strobe
//   weight_wr_idx   in   [IDX_W]     client whose weight is written
//   weight_wr_data  in   [WEIGHT_W]  new weight (0 behaves as 1)
//   grant           out  [CLIENTS]   registered one-hot grant, zero when idle/stalled
//   grant_valid     out  |grant
//   grant_idx       out  [IDX_W]     encoded grant index, 0 when grant_valid=0
// -----------------------------------------------------------------------------
module wrr_arbiter #(
   parameter int CLIENTS  = 8,
   parameter int WEIGHT_W = 4,
   localparam int IDX_W   = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CLIENTS-1:0]  request,
   input  logic                stall,
   input  logic                weight_wr_en,
   input  logic [IDX_W-1:0]    weight_wr_idx,
   input  logic [WEIGHT_W-1:0] weight_wr_data,
   output logic [CLIENTS-1:0]  grant,
   output logic                grant_valid,
   output logic [IDX_W-1:0]    grant_idx
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [WEIGHT_W-1:0] quota_q, quota_d;
   logic [CLIENTS-1:0]  grant_q, grant_d;
   logic                valid_q, valid_d;
   logic [IDX_W-1:0]    gidx_q, gidx_d;
   logic [WEIGHT_W-1:0] weight_q [CLIENTS];

   logic                found_s;
   logic [IDX_W-1:0]    found_idx_s;

   // A zero weight still grants one cycle so a client can never be starved.
   function automatic logic [WEIGHT_W-1:0] eff_quota(input logic [WEIGHT_W-1:0] w);
      return (w == '0) ? WEIGHT_W'(1) : w;
   endfunction

   // Round-robin search: owner+1 first, wrapping, owner itself checked last.
   always_comb begin
      int cand;
      cand        = 0;
      found_s     = 1'b0;
      found_idx_s = '0;
      for (int i = 1; i <= CLIENTS; i++) begin
         cand = (int'(owner_q) + i) % CLIENTS;
         if (!found_s && request[cand[IDX_W-1:0]]) begin
            found_s     = 1'b1;
            found_idx_s = cand[IDX_W-1:0];
         end else begin
            found_s     = found_s;
         end
      end
   end

   // Next-state and next-grant logic. During stall the grant drops but
   // state, owner and remaining quota are held untouched.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      quota_d = quota_q;
      grant_d = '0;
      valid_d = 1'b0;
      gidx_d  = '0;
      if (!stall) begin
         case (state_q)
            ST_IDLE: begin
               if (found_s) begin
                  state_d = ST_GRANT;
                  owner_d = found_idx_s;
                  quota_d = eff_quota(weight_q[found_idx_s]);
                  grant_d = CLIENTS'(1) << found_idx_s;
                  valid_d = 1'b1;
                  gidx_d  = found_idx_s;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (request[owner_q] && (quota_q > WEIGHT_W'(1))) begin
                  quota_d = quota_q - WEIGHT_W'(1);
                  grant_d = CLIENTS'(1) << owner_q;
                  valid_d = 1'b1;
                  gidx_d  = owner_q;
               end else if (found_s) begin
                  // Fresh burst; may re-select the same owner if it is alone.
                  owner_d = found_idx_s;
                  quota_d = eff_quota(weight_q[found_idx_s]);
                  grant_d = CLIENTS'(1) << found_idx_s;
                  valid_d = 1'b1;
                  gidx_d  = found_idx_s;
               end else begin
                  // Owner is kept so the next search still starts after it.
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         grant_d = '0;
      end
   end

   // Scheduler state and registered grant outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= IDX_W'(CLIENTS - 1);
         quota_q <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         gidx_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         quota_q <= quota_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         gidx_q  <= gidx_d;
      end
   end

   // Weight registers; a load on the same edge as a write sees the old value.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CLIENTS; i++) begin
            weight_q[i] <= WEIGHT_W'(1);
         end
      end else if (weight_wr_en && (int'(weight_wr_idx) < CLIENTS)) begin
         weight_q[weight_wr_idx] <= weight_wr_data;
      end else begin
         weight_q <= weight_q;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = valid_q;
   assign grant_idx   = gidx_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Testbench for wrr_arbiter: directed scenarios followed by a randomized
// phase, all checked against a burst-counting reference model.
module tb_wrr_arbiter;
   localparam int N  = 8;
   localparam int WW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  request = '0;
   logic          stall = 1'b0;
   logic          weight_wr_en = 1'b0;
   logic [2:0]    weight_wr_idx = '0;
   logic [WW-1:0] weight_wr_data = '0;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [2:0]    grant_idx;

   wrr_arbiter #(.CLIENTS(N), .WEIGHT_W(WW)) dut (
      .clock(clock), .reset(reset), .request(request), .stall(stall),
      .weight_wr_en(weight_wr_en), .weight_wr_idx(weight_wr_idx),
      .weight_wr_data(weight_wr_data), .grant(grant),
      .grant_valid(grant_valid), .grant_idx(grant_idx)
   );

   always #5 clock = ~clock;

   // Reference model: who holds the slot, how many grants its current burst
   // has used, and how long that burst may be.
   int           m_owner, m_used, m_quota;
   bit           m_active;
   int           m_weight [N];
   logic [N-1:0] exp_grant;
   int           n_cmp = 0;
   int           n_bad = 0;

   function automatic int eff(input int w);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic void model_reset();
      m_owner = N - 1; m_used = 0; m_quota = 0; m_active = 0; exp_grant = '0;
      for (int i = 0; i < N; i++) m_weight[i] = 1;
   endfunction

   function automatic void model_edge();
      bit found;
      int k;
      if (stall) begin
         exp_grant = '0;
      end else if (m_active && request[m_owner] && m_used < m_quota) begin
         m_used++;
         exp_grant = '0; exp_grant[m_owner] = 1'b1;
      end else begin
         found = 0;
         exp_grant = '0;
         for (int i = 1; i <= N; i++) begin
            k = (m_owner + i) % N;
            if (!found && request[k]) begin
               found = 1; m_owner = k; m_used = 1; m_quota = eff(m_weight[k]);
               exp_grant[k] = 1'b1;
            end
         end
         m_active = found;
      end
      if (weight_wr_en && int'(weight_wr_idx) < N) m_weight[weight_wr_idx] = int'(weight_wr_data);
   endfunction

   task automatic check(input string tag);
      logic [2:0] eidx;
      eidx = '0;
      for (int i = 0; i < N; i++) if (exp_grant[i]) eidx = 3'(i);
      n_cmp++;
      assert (grant === exp_grant) else begin
         n_bad++; $error("FAIL %s grant observed=%b expected=%b", tag, grant, exp_grant);
      end
      n_cmp++;
      assert (grant_valid === (|exp_grant)) else begin
         n_bad++; $error("FAIL %s grant_valid observed=%b expected=%b", tag, grant_valid, |exp_grant);
      end
      n_cmp++;
      assert (grant_idx === eidx) else begin
         n_bad++; $error("FAIL %s grant_idx observed=%0d expected=%0d", tag, grant_idx, eidx);
      end
   endtask

   // One clock: apply inputs, let the edge happen, compare on the falling edge.
   task automatic step(input string tag, input logic [N-1:0] req, input logic stl,
                       input logic we = 1'b0, input logic [2:0] wi = 3'd0,
                       input logic [WW-1:0] wd = 4'd0);
      request = req; stall = stl;
      weight_wr_en = we; weight_wr_idx = wi; weight_wr_data = wd;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      weight_wr_en = 1'b0;
      check(tag);
   endtask

   task automatic expect_idx(input string tag, input logic [2:0] want);
      n_cmp++;
      assert (grant_valid === 1'b1 && grant_idx === want) else begin
         n_bad++; $error("FAIL %s observed valid=%b idx=%0d expected valid=1 idx=%0d",
                         tag, grant_valid, grant_idx, want);
      end
   endtask

   logic [N-1:0] rreq;

   initial begin
      model_reset();
      #1;
      check("reset");
      @(negedge clock);
      reset = 1'b0;

      // 1: default weights alternate between clients 0 and 2.
      step("t1_first", 8'h05, 1'b0);
      expect_idx("t1_first_is0", 3'd0);
      step("t1_second", 8'h05, 1'b0);
      expect_idx("t1_second_is2", 3'd2);
      for (int i = 0; i < 4; i++) step("t1_alt", 8'h05, 1'b0);

      // 2: weight 3 on client 0 gives 0,0,0,2 bursts.
      step("t2_wr0", 8'h00, 1'b0, 1'b1, 3'd0, 4'd3);
      step("t2_wr2", 8'h00, 1'b0, 1'b1, 3'd2, 4'd1);
      for (int i = 0; i < 8; i++) step("t2_burst", 8'h05, 1'b0);

      // 3: weight 0 acts as 1; a lone requester re-grants itself by wrapping.
      step("t3_wr3", 8'h00, 1'b0, 1'b1, 3'd3, 4'd0);
      for (int i = 0; i < 4; i++) step("t3_self", 8'h08, 1'b0);
      expect_idx("t3_self_is3", 3'd3);

      // 4: stall in the middle of a weight-4 burst preserves the quota.
      step("t4_wr1", 8'h00, 1'b0, 1'b1, 3'd1, 4'd4);
      step("t4_g1a", 8'h02, 1'b0);
      step("t4_g1b", 8'h02, 1'b0);
      step("t4_stall_a", 8'h12, 1'b1);
      step("t4_stall_b", 8'h12, 1'b1);
      step("t4_g1c", 8'h12, 1'b0);
      step("t4_g1d", 8'h12, 1'b0);
      expect_idx("t4_last1", 3'd1);
      step("t4_g4", 8'h12, 1'b0);
      expect_idx("t4_then4", 3'd4);

      // 5: owner drops mid-quota; idle keeps the search pointer after 6.
      step("t5_wr5", 8'h00, 1'b0, 1'b1, 3'd5, 4'd3);
      step("t5_g5", 8'h20, 1'b0);
      step("t5_g6", 8'h40, 1'b0);
      expect_idx("t5_is6", 3'd6);
      step("t5_idle", 8'h00, 1'b0);
      step("t5_next7", 8'h81, 1'b0);
      expect_idx("t5_next_is7", 3'd7);

      // 6: asynchronous reset during a weight-3 burst.
      step("t6_wr2", 8'h00, 1'b0, 1'b1, 3'd2, 4'd3);
      step("t6_b1", 8'h04, 1'b0);
      step("t6_b2", 8'h04, 1'b0);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("t6_async_reset");
      @(negedge clock);
      reset = 1'b0;
      step("t6_after5", 8'hA0, 1'b0);
      expect_idx("t6_first5", 3'd5);
      step("t6_quota1", 8'hA0, 1'b0);
      expect_idx("t6_then7", 3'd7);

      // Randomized traffic: requests stay up until granted, random stalls
      // and weight writes.
      rreq = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!rreq[i]) rreq[i] = ($urandom_range(0, 9) < 3);
            else if (exp_grant[i]) rreq[i] = ($urandom_range(0, 1) == 1);
         end
         step("rand", rreq, ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 6) == 0), 3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
